// File: rtl/keypad_digit_controller_if.sv
// rtl/keypad_digit_controller_if.sv - scanner inputs and display-side outputs of the keypad digit controller
interface keypad_digit_controller_if;
  logic       key_pressed;
  logic [3:0] key_value;
  logic [3:0] digit_left;
  logic [3:0] digit_right;
  logic       new_digit;
  logic [3:0] seg_digit;
  logic       en_left;
  logic       en_right;

  modport master (
    output key_pressed, key_value,
    input  digit_left, digit_right, new_digit, seg_digit, en_left, en_right
  );

  modport slave (
    input  key_pressed, key_value,
    output digit_left, digit_right, new_digit, seg_digit, en_left, en_right
  );
endinterface

// File: rtl/keypad_digit_controller.sv
// rtl/keypad_digit_controller.sv - debounced two-digit key history and two-digit display multiplexer
module keypad_digit_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MUX_CYCLES      = 20000
) (
  input  logic                      clk,
  input  logic                      reset,
  keypad_digit_controller_if.slave  kif
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int MW = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [MW-1:0] MUX_LAST = MW'(MUX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    cand, cand_n;
  logic [3:0]    left, left_n, right, right_n;
  logic          new_digit, new_n;
  logic [MW-1:0] mux_cnt, mux_n;
  logic          sel, sel_n;
  logic          en_left, en_left_n, en_right, en_right_n;
  logic [3:0]    seg, seg_n;
  logic          mux_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      left      <= '0;
      right     <= '0;
      new_digit <= 1'b0;
      mux_cnt   <= '0;
      sel       <= 1'b0;
      en_left   <= 1'b0;
      en_right  <= 1'b0;
      seg       <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      left      <= left_n;
      right     <= right_n;
      new_digit <= new_n;
      mux_cnt   <= mux_n;
      sel       <= sel_n;
      en_left   <= en_left_n;
      en_right  <= en_right_n;
      seg       <= seg_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    left_n  = left;
    right_n = right;
    new_n   = 1'b0;
    case (state)
      IDLE: begin
        if (kif.key_pressed) begin
          cand_n  = kif.key_value;
          cnt_n   = '0;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // A value change mid-debounce restarts qualification on the new key
        if (!kif.key_pressed) begin
          state_n = IDLE;
        end else if (kif.key_value != cand) begin
          cand_n = kif.key_value;
          cnt_n  = '0;
        end else if (cnt == CNT_LAST) begin
          left_n  = right;
          right_n = cand;
          new_n   = 1'b1;
          state_n = HELD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!kif.key_pressed) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (kif.key_pressed) begin
          state_n = HELD;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  // Enables and seg are computed from the next slot position so they line up with mux_cnt
  always_comb begin
    mux_wrap   = (mux_cnt == MUX_LAST);
    mux_n      = mux_wrap ? '0 : mux_cnt + 1'b1;
    sel_n      = sel ^ mux_wrap;
    en_left_n  = (mux_n != '0) && sel_n;
    en_right_n = (mux_n != '0) && !sel_n;
    seg_n      = sel_n ? left : right;
  end

  assign kif.digit_left  = left;
  assign kif.digit_right = right;
  assign kif.new_digit   = new_digit;
  assign kif.seg_digit   = seg;
  assign kif.en_left     = en_left;
  assign kif.en_right    = en_right;

endmodule

// File: tb/tb_keypad_digit_controller.sv
// tb/tb_keypad_digit_controller.sv - directed self-checking bench for keypad_digit_controller
module tb_keypad_digit_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   cyc = 0;
  int   base;

  keypad_digit_controller_if kif();

  keypad_digit_controller #(.DEBOUNCE_CYCLES(4), .MUX_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  // Reference slot position: edges since reset released
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (kif.new_digit === 1'b1) pulses <= pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    kif.key_pressed = 1'b0;
    kif.key_value = 4'h0;
    tick(2);
    checks++; if (kif.digit_left !== 4'h0) begin errors++; $display("FAIL reset_left got=%h exp=0", kif.digit_left); end
    checks++; if (kif.digit_right !== 4'h0) begin errors++; $display("FAIL reset_right got=%h exp=0", kif.digit_right); end
    checks++; if (kif.new_digit !== 1'b0) begin errors++; $display("FAIL reset_new got=%b exp=0", kif.new_digit); end
    checks++; if ({kif.en_left, kif.en_right} !== 2'b00) begin errors++; $display("FAIL reset_en got=%b%b exp=00", kif.en_left, kif.en_right); end
    checks++; if (kif.seg_digit !== 4'h0) begin errors++; $display("FAIL reset_seg got=%h exp=0", kif.seg_digit); end
    reset = 1'b0;
    tick(1);
    checks++; if ({kif.en_left, kif.en_right} !== 2'b01) begin errors++; $display("FAIL first_slot_en got=%b%b exp=01", kif.en_left, kif.en_right); end
    checks++; if (kif.seg_digit !== 4'h0) begin errors++; $display("FAIL first_slot_seg got=%h exp=0", kif.seg_digit); end
  endtask

  task automatic test_clean_press;
    kif.key_value = 4'hA;
    kif.key_pressed = 1'b1;
    tick(4);
    checks++; if (kif.new_digit !== 1'b0) begin errors++; $display("FAIL press_early got=%b exp=0", kif.new_digit); end
    tick(1);
    checks++; if (kif.new_digit !== 1'b1) begin errors++; $display("FAIL press_pulse got=%b exp=1", kif.new_digit); end
    checks++; if (kif.digit_right !== 4'hA) begin errors++; $display("FAIL press_right got=%h exp=a", kif.digit_right); end
    checks++; if (kif.digit_left !== 4'h0) begin errors++; $display("FAIL press_left got=%h exp=0", kif.digit_left); end
    tick(1);
    checks++; if (kif.new_digit !== 1'b0) begin errors++; $display("FAIL press_pulse_width got=%b exp=0", kif.new_digit); end
    base = pulses;
    tick(5);
    checks++; if (pulses !== base) begin errors++; $display("FAIL held_extra_pulses got=%0d exp=0", pulses - base); end
  endtask

  task automatic test_second_key;
    kif.key_pressed = 1'b0;
    tick(6);
    base = pulses;
    kif.key_value = 4'h5;
    kif.key_pressed = 1'b1;
    tick(5);
    checks++; if (kif.new_digit !== 1'b1) begin errors++; $display("FAIL second_pulse got=%b exp=1", kif.new_digit); end
    checks++; if (kif.digit_left !== 4'hA) begin errors++; $display("FAIL second_left got=%h exp=a", kif.digit_left); end
    checks++; if (kif.digit_right !== 4'h5) begin errors++; $display("FAIL second_right got=%h exp=5", kif.digit_right); end
    tick(1);
    checks++; if (pulses - base !== 1) begin errors++; $display("FAIL second_pulse_count got=%0d exp=1", pulses - base); end
    kif.key_pressed = 1'b0;
    tick(6);
  endtask

  task automatic test_mux;
    int m;
    int s;
    logic exp_l;
    logic exp_r;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      m = cyc % 4;
      s = (cyc / 4) % 2;
      exp_l = (m != 0) && (s == 1);
      exp_r = (m != 0) && (s == 0);
      checks++; if ({kif.en_left, kif.en_right} !== {exp_l, exp_r}) begin errors++; $display("FAIL mux_en cyc=%0d got=%b%b exp=%b%b", cyc, kif.en_left, kif.en_right, exp_l, exp_r); end
      if (m != 0) begin
        checks++; if (kif.seg_digit !== ((s == 1) ? 4'hA : 4'h5)) begin errors++; $display("FAIL mux_seg cyc=%0d got=%h exp=%h", cyc, kif.seg_digit, (s == 1) ? 4'hA : 4'h5); end
      end
      checks++; if ((kif.en_left & kif.en_right) !== 1'b0) begin errors++; $display("FAIL mux_both_en cyc=%0d got=1 exp=0", cyc); end
    end
  endtask

  task automatic test_press_bounce;
    base = pulses;
    kif.key_value = 4'h7;
    kif.key_pressed = 1'b1;
    tick(2);
    kif.key_pressed = 1'b0;
    tick(1);
    kif.key_pressed = 1'b1;
    tick(2);
    kif.key_pressed = 1'b0;
    tick(3);
    checks++; if (pulses !== base) begin errors++; $display("FAIL bounce_pulses got=%0d exp=0", pulses - base); end
    checks++; if ({kif.digit_left, kif.digit_right} !== 8'hA5) begin errors++; $display("FAIL bounce_digits got=%h exp=a5", {kif.digit_left, kif.digit_right}); end
    kif.key_value = 4'h2;
    kif.key_pressed = 1'b1;
    tick(4);
    checks++; if (kif.new_digit !== 1'b0) begin errors++; $display("FAIL bounce_idle_early got=%b exp=0", kif.new_digit); end
    tick(1);
    checks++; if (kif.new_digit !== 1'b1) begin errors++; $display("FAIL bounce_idle_pulse got=%b exp=1", kif.new_digit); end
    checks++; if ({kif.digit_left, kif.digit_right} !== 8'h52) begin errors++; $display("FAIL bounce_after_digits got=%h exp=52", {kif.digit_left, kif.digit_right}); end
    kif.key_pressed = 1'b0;
    tick(6);
  endtask

  task automatic test_release_bounce;
    base = pulses;
    kif.key_value = 4'h9;
    kif.key_pressed = 1'b1;
    tick(5);
    checks++; if (kif.new_digit !== 1'b1) begin errors++; $display("FAIL rel_commit got=%b exp=1", kif.new_digit); end
    checks++; if ({kif.digit_left, kif.digit_right} !== 8'h29) begin errors++; $display("FAIL rel_digits got=%h exp=29", {kif.digit_left, kif.digit_right}); end
    tick(1);
    kif.key_pressed = 1'b0;
    tick(2);
    kif.key_pressed = 1'b1;
    tick(1);
    kif.key_pressed = 1'b0;
    tick(6);
    checks++; if (pulses - base !== 1) begin errors++; $display("FAIL rel_pulse_count got=%0d exp=1", pulses - base); end
    checks++; if ({kif.digit_left, kif.digit_right} !== 8'h29) begin errors++; $display("FAIL rel_digits_after got=%h exp=29", {kif.digit_left, kif.digit_right}); end
    kif.key_value = 4'h1;
    kif.key_pressed = 1'b1;
    tick(4);
    checks++; if (kif.new_digit !== 1'b0) begin errors++; $display("FAIL rel_idle_early got=%b exp=0", kif.new_digit); end
    tick(1);
    checks++; if (kif.new_digit !== 1'b1) begin errors++; $display("FAIL rel_idle_pulse got=%b exp=1", kif.new_digit); end
    kif.key_pressed = 1'b0;
    tick(6);
  endtask

  task automatic test_reset_mid_debounce;
    kif.key_value = 4'h3;
    kif.key_pressed = 1'b1;
    tick(2);
    base = pulses;
    reset = 1'b1;
    #1;
    checks++; if ({kif.digit_left, kif.digit_right} !== 8'h00) begin errors++; $display("FAIL rstmid_digits got=%h exp=00", {kif.digit_left, kif.digit_right}); end
    checks++; if (kif.new_digit !== 1'b0) begin errors++; $display("FAIL rstmid_new got=%b exp=0", kif.new_digit); end
    checks++; if ({kif.en_left, kif.en_right} !== 2'b00) begin errors++; $display("FAIL rstmid_en got=%b%b exp=00", kif.en_left, kif.en_right); end
    checks++; if (kif.seg_digit !== 4'h0) begin errors++; $display("FAIL rstmid_seg got=%h exp=0", kif.seg_digit); end
    tick(2);
    kif.key_pressed = 1'b0;
    reset = 1'b0;
    tick(6);
    checks++; if (pulses !== base) begin errors++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses - base); end
    checks++; if ({kif.digit_left, kif.digit_right} !== 8'h00) begin errors++; $display("FAIL rstmid_digits_after got=%h exp=00", {kif.digit_left, kif.digit_right}); end
  endtask

  initial begin
    kif.key_pressed = 1'b0;
    kif.key_value = 4'h0;
    test_reset();
    test_clean_press();
    test_second_key();
    test_mux();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
